// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants plus the output-size and window-packing helpers used by the window generator and the MAC core.
package cnn_pkg;

  localparam int unsigned I_BW_DEF = 8;
  localparam int unsigned CI_DEF   = 1;
  localparam int unsigned IX_DEF   = 28;
  localparam int unsigned IY_DEF   = 28;
  localparam int unsigned KX_DEF   = 5;
  localparam int unsigned KY_DEF   = 5;

  // Number of window positions along one axis.
  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                          input int unsigned stride);
    return (in_dim - k) / stride + 1;
  endfunction

  // Bit offset of element (ky,kx,c) inside a packed window.
  function automatic int unsigned win_offset(input int unsigned ky, input int unsigned kx,
                                             input int unsigned c, input int unsigned kx_n,
                                             input int unsigned ci, input int unsigned bw);
    return ((ky * kx_n + kx) * ci + c) * bw;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage: synchronous write, asynchronous read at the same column address.
module line_buffer_ram
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = IX_DEF,
  parameter int unsigned W     = CI_DEF * I_BW_DEF,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_c_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KX x KY sliding-window generator with valid/ready handshake, output-map coordinates and end-of-frame flag.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned I_BW   = I_BW_DEF,
  parameter int unsigned CI     = CI_DEF,
  parameter int unsigned IX     = IX_DEF,
  parameter int unsigned IY     = IY_DEF,
  parameter int unsigned KX     = KX_DEF,
  parameter int unsigned KY     = KY_DEF,
  parameter int unsigned STRIDE = 1,
  localparam int unsigned OUT_W = out_dim(IX, KX, STRIDE),
  localparam int unsigned OUT_H = out_dim(IY, KY, STRIDE),
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [CI*I_BW-1:0]        i_pixel,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [KY*KX*CI*I_BW-1:0]  o_window,
  output logic [XW-1:0]             o_x,
  output logic [YW-1:0]             o_y,
  output logic                      o_last
);

  localparam int unsigned PW = CI * I_BW;
  localparam int unsigned WW = KY * KX * PW;
  localparam int unsigned CW = (IX > 1) ? $clog2(IX) : 1;
  localparam int unsigned RW = (IY > 1) ? $clog2(IY) : 1;

  logic [CW-1:0] col_q, col_d, col_rel_c;
  logic [RW-1:0] row_q, row_d, row_rel_c;
  logic          valid_q, valid_d;
  logic [XW-1:0] x_q, x_d, win_x_c;
  logic [YW-1:0] y_q, y_d, win_y_c;
  logic          last_q, last_d;
  logic          accept_c, emit_c;
  logic [PW-1:0] col_in [KY];
  logic [PW-1:0] win_q [KY][KX];
  logic [PW-1:0] win_d [KY][KX];
  logic [WW-1:0] win_flat_c;

  assign i_ready  = !valid_q || o_ready;
  assign accept_c = i_valid && i_ready && !i_clear;

  // New right-hand column: KY-1 older rows from the line buffers, current pixel at the bottom.
  assign col_in[KY-1] = i_pixel;

  for (genvar k = 0; k < KY - 1; k++) begin : g_lb
    line_buffer_ram #(
      .DEPTH (IX),
      .W     (PW)
    ) u_lb (
      .clk       (clk),
      .we_i      (accept_c),
      .addr_i    (col_q),
      .wdata_i   (col_in[k+1]),
      .rdata_c_o (col_in[k])
    );
  end

  always_comb begin
    for (int unsigned ky = 0; ky < KY; ky++) begin
      for (int unsigned kx = 0; kx < KX; kx++) begin
        win_d[ky][kx] = win_q[ky][kx];
      end
    end
    if (accept_c) begin
      for (int unsigned ky = 0; ky < KY; ky++) begin
        for (int unsigned kx = 0; kx + 1 < KX; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
        win_d[ky][KX-1] = col_in[ky];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned ky = 0; ky < KY; ky++) begin
        for (int unsigned kx = 0; kx < KX; kx++) begin
          win_q[ky][kx] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  always_comb begin
    win_flat_c = '0;
    for (int unsigned ky = 0; ky < KY; ky++) begin
      for (int unsigned kx = 0; kx < KX; kx++) begin
        win_flat_c[win_offset(ky, kx, 0, KX, CI, I_BW) +: PW] = win_q[ky][kx];
      end
    end
  end

  // Window placement test for the pixel being accepted this cycle.
  always_comb begin
    col_rel_c = col_q - CW'(KX - 1);
    row_rel_c = row_q - RW'(KY - 1);
    win_x_c   = XW'(col_rel_c / CW'(STRIDE));
    win_y_c   = YW'(row_rel_c / RW'(STRIDE));
    emit_c    = accept_c
             && (col_q >= CW'(KX - 1)) && (row_q >= RW'(KY - 1))
             && ((col_rel_c % CW'(STRIDE)) == '0)
             && ((row_rel_c % RW'(STRIDE)) == '0);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_clear) begin
      col_d = '0;
      row_d = '0;
    end else if (accept_c) begin
      if (col_q == CW'(IX - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IY - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    last_d  = last_q;
    if (i_clear) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (emit_c) begin
      valid_d = 1'b1;
      x_d     = win_x_c;
      y_d     = win_y_c;
      last_d  = (win_x_c == XW'(OUT_W - 1)) && (win_y_c == YW'(OUT_H - 1));
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
    end
  end

  // The window register only moves on accept, which cannot happen while a window is stalled.
  assign o_window = win_flat_c;
  assign o_valid  = valid_q;
  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_last   = last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: stride-1 and stride-2 instances share one accepted pixel stream and are scored against a frame-array model.
module tb_conv_window_gen;

  localparam int unsigned I_BW = 8;
  localparam int unsigned CI   = 3;
  localparam int unsigned IX   = 28;
  localparam int unsigned IY   = 28;
  localparam int unsigned KX   = 5;
  localparam int unsigned KY   = 5;
  localparam int unsigned PW   = CI * I_BW;
  localparam int unsigned WW   = KY * KX * PW;
  localparam int unsigned XW1  = $clog2((IX - KX) / 1 + 1);
  localparam int unsigned YW1  = $clog2((IY - KY) / 1 + 1);
  localparam int unsigned XW2  = $clog2((IX - KX) / 2 + 1);
  localparam int unsigned YW2  = $clog2((IY - KY) / 2 + 1);

  logic clk = 1'b0;
  logic reset_n, i_clear, vld;
  logic [PW-1:0] i_pixel;
  logic i_valid_s1, i_ready_s1, o_valid_s1, o_ready_s1, o_last_s1;
  logic i_valid_s2, i_ready_s2, o_valid_s2, o_ready_s2, o_last_s2;
  logic [WW-1:0]  o_window_s1, o_window_s2;
  logic [XW1-1:0] o_x_s1;
  logic [YW1-1:0] o_y_s1;
  logic [XW2-1:0] o_x_s2;
  logic [YW2-1:0] o_y_s2;

  always #5 clk = ~clk;

  // A pixel is offered to both instances only when both can take it, keeping their streams identical.
  assign i_valid_s1 = vld && i_ready_s1 && i_ready_s2;
  assign i_valid_s2 = vld && i_ready_s1 && i_ready_s2;

  conv_window_gen #(.I_BW(I_BW), .CI(CI), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .STRIDE(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid_s1), .i_ready(i_ready_s1),
    .i_pixel(i_pixel), .o_valid(o_valid_s1), .o_ready(o_ready_s1), .o_window(o_window_s1),
    .o_x(o_x_s1), .o_y(o_y_s1), .o_last(o_last_s1));

  conv_window_gen #(.I_BW(I_BW), .CI(CI), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .STRIDE(2)) u_s2 (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid_s2), .i_ready(i_ready_s2),
    .i_pixel(i_pixel), .o_valid(o_valid_s2), .o_ready(o_ready_s2), .o_window(o_window_s2),
    .o_x(o_x_s2), .o_y(o_y_s2), .o_last(o_last_s2));

  typedef struct {
    logic [WW-1:0] win;
    int            x;
    int            y;
    bit            last;
    int            n;
  } exp_t;

  typedef struct {
    int inst; int n; int ky; int kx; int c; int val; int x; int y; int last;
  } tv_t;

  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic [PW-1:0] frame [IY][IX];
  int m_row, m_col;
  int m_n [2];
  int tot_win [2];
  int tot_last [2];
  bit table_en;
  tv_t tv [12];
  int tv_hits [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ramp_pix(input int r, input int c);
    logic [PW-1:0] p;
    int base;
    base = (r * IX + c) % 256;
    for (int ch = 0; ch < CI; ch++) p[ch*I_BW +: I_BW] = 8'((base + ch * 64) % 256);
    return p;
  endfunction

  function automatic logic [PW-1:0] pix_next(input int mode);
    if (mode == 0) return ramp_pix(m_row, m_col);
    return PW'($urandom);
  endfunction

  // Neighbourhood read straight from the stored frame, top-left element first.
  function automatic logic [WW-1:0] build_win(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++)
        w[((ky * KX + kx) * CI) * I_BW +: PW] = frame[r - KY + 1 + ky][c - KX + 1 + kx];
    return w;
  endfunction

  task automatic model_clear();
    q1.delete();
    q2.delete();
    m_row = 0;
    m_col = 0;
    m_n[0] = 0;
    m_n[1] = 0;
  endtask

  task automatic model_accept(input logic [PW-1:0] pix);
    frame[m_row][m_col] = pix;
    for (int s = 1; s <= 2; s++) begin
      int ry, cx;
      ry = m_row - (KY - 1);
      cx = m_col - (KX - 1);
      if (ry >= 0 && cx >= 0 && ry % s == 0 && cx % s == 0) begin
        exp_t e;
        e.win  = build_win(m_row, m_col);
        e.x    = cx / s;
        e.y    = ry / s;
        e.last = (e.x == (IX - KX) / s) && (e.y == (IY - KY) / s);
        e.n    = m_n[s-1];
        m_n[s-1]++;
        if (s == 1) q1.push_back(e); else q2.push_back(e);
      end
    end
    if (m_col == IX - 1) begin
      m_col = 0;
      if (m_row == IY - 1) begin
        m_row = 0;
        m_n[0] = 0;
        m_n[1] = 0;
      end else m_row++;
    end else m_col++;
  endtask

  task automatic out_check(input int inst, input bit rdy);
    exp_t e;
    logic [WW-1:0] w;
    int x, y;
    bit l;
    if ((inst == 0 && q1.size() == 0) || (inst == 1 && q2.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL spurious_window inst=%0d actual=valid required=none", inst);
      return;
    end
    if (inst == 0) begin
      e = q1[0]; w = o_window_s1; x = int'(o_x_s1); y = int'(o_y_s1); l = o_last_s1;
    end else begin
      e = q2[0]; w = o_window_s2; x = int'(o_x_s2); y = int'(o_y_s2); l = o_last_s2;
    end
    chk_w(inst == 0 ? "window_s1" : "window_s2", w, e.win);
    chk(inst == 0 ? "x_s1" : "x_s2", 64'(x), 64'(e.x));
    chk(inst == 0 ? "y_s1" : "y_s2", 64'(y), 64'(e.y));
    chk(inst == 0 ? "last_s1" : "last_s2", 64'(l), 64'(e.last));
    if (rdy) begin
      if (table_en) begin
        for (int i = 0; i < 12; i++) begin
          if (tv[i].inst == inst && tv[i].n == e.n) begin
            chk($sformatf("tv%0d_elem", i),
                64'(w[((tv[i].ky * KX + tv[i].kx) * CI + tv[i].c) * I_BW +: I_BW]), 64'(tv[i].val));
            chk($sformatf("tv%0d_x", i), 64'(x), 64'(tv[i].x));
            chk($sformatf("tv%0d_y", i), 64'(y), 64'(tv[i].y));
            chk($sformatf("tv%0d_last", i), 64'(l), 64'(tv[i].last));
            tv_hits[i]++;
          end
        end
      end
      tot_win[inst]++;
      if (l) tot_last[inst]++;
      if (inst == 0) void'(q1.pop_front()); else void'(q2.pop_front());
    end
  endtask

  // One clock: check registered state, drive new inputs, score any handshake, advance the model.
  task automatic step(input bit v, input bit r1, input bit r2, input bit clr,
                      input logic [PW-1:0] pix, output bit acc);
    @(negedge clk);
    chk("o_valid_s1", 64'(o_valid_s1), 64'(q1.size() != 0));
    chk("o_valid_s2", 64'(o_valid_s2), 64'(q2.size() != 0));
    vld = v; o_ready_s1 = r1; o_ready_s2 = r2; i_clear = clr; i_pixel = pix;
    #1;
    chk("i_ready_s1", 64'(i_ready_s1), 64'(q1.size() == 0 || r1));
    chk("i_ready_s2", 64'(i_ready_s2), 64'(q2.size() == 0 || r2));
    if (o_valid_s1) out_check(0, r1);
    if (o_valid_s2) out_check(1, r2);
    acc = !clr && v && i_ready_s1 && i_ready_s2;
    if (clr) model_clear();
    else if (acc) model_accept(pix);
  endtask

  task automatic run_pixels(input int mode, input int npix, input bit rnd, input int stall_at);
    int acc_n, cyc;
    bit a, stalled, v, r1, r2;
    acc_n = 0; cyc = 0; stalled = 0;
    while (acc_n < npix && cyc < 20000) begin
      v = 1; r1 = 1; r2 = 1;
      if (rnd) begin
        v  = ($urandom_range(0, 3) != 0);
        r1 = ($urandom_range(0, 3) != 0);
        r2 = ($urandom_range(0, 3) != 0);
      end
      if (stall_at >= 0 && acc_n == stall_at && !stalled) begin
        stalled = 1;
        repeat (3) begin
          step(1, 0, 0, 0, pix_next(mode), a);
          chk("bp_iready_s1", 64'(i_ready_s1), 64'(0));
          if (a) acc_n++;
          cyc++;
        end
      end
      step(v, r1, r2, 0, pix_next(mode), a);
      if (a) acc_n++;
      cyc++;
    end
    if (acc_n < npix) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=%0d", acc_n, npix);
    end
  endtask

  task automatic drain();
    bit a;
    repeat (3) step(0, 1, 1, 0, '0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; vld = 0; i_clear = 0; o_ready_s1 = 1; o_ready_s2 = 1;
    model_clear();
    #1;
    chk("rst_valid_s1", 64'(o_valid_s1), 64'(0));
    chk("rst_valid_s2", 64'(o_valid_s2), 64'(0));
    chk("rst_x_s1", 64'(o_x_s1), 64'(0));
    chk("rst_y_s1", 64'(o_y_s1), 64'(0));
    chk("rst_last_s1", 64'(o_last_s1), 64'(0));
    chk("rst_last_s2", 64'(o_last_s2), 64'(0));
    chk_w("rst_window_s1", o_window_s1, '0);
    chk_w("rst_window_s2", o_window_s2, '0);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic seg_start();
    tot_win[0] = 0; tot_win[1] = 0; tot_last[0] = 0; tot_last[1] = 0;
  endtask

  task automatic seg_check(input string nm, input int w1, input int w2, input int l1, input int l2);
    chk({nm, "_windows_s1"}, 64'(tot_win[0]), 64'(w1));
    chk({nm, "_windows_s2"}, 64'(tot_win[1]), 64'(w2));
    chk({nm, "_lasts_s1"}, 64'(tot_last[0]), 64'(l1));
    chk({nm, "_lasts_s2"}, 64'(tot_last[1]), 64'(l2));
  endtask

  initial begin
    bit a;
    // {inst, window index in frame, ky, kx, c, value, o_x, o_y, o_last} for a ramp frame
    tv[0]  = '{0, 0,   0, 0, 0, 0,   0,  0,  0};
    tv[1]  = '{0, 0,   4, 4, 0, 116, 0,  0,  0};
    tv[2]  = '{0, 0,   4, 4, 2, 244, 0,  0,  0};
    tv[3]  = '{0, 0,   0, 0, 1, 64,  0,  0,  0};
    tv[4]  = '{0, 0,   1, 3, 0, 31,  0,  0,  0};
    tv[5]  = '{0, 0,   3, 1, 0, 85,  0,  0,  0};
    tv[6]  = '{0, 24,  0, 0, 0, 28,  0,  1,  0};
    tv[7]  = '{0, 575, 4, 4, 0, 15,  23, 23, 1};
    tv[8]  = '{0, 575, 0, 0, 0, 155, 23, 23, 1};
    tv[9]  = '{1, 13,  0, 0, 0, 58,  1,  1,  0};
    tv[10] = '{1, 143, 4, 4, 0, 242, 11, 11, 1};
    tv[11] = '{1, 143, 0, 0, 1, 190, 11, 11, 1};
    for (int i = 0; i < 12; i++) tv_hits[i] = 0;
    reset_n = 0; i_clear = 0; vld = 0; i_pixel = '0; o_ready_s1 = 1; o_ready_s2 = 1;
    table_en = 0;

    do_reset();

    // Ramp frame at full rate with a 3-cycle output stall.
    seg_start(); table_en = 1;
    run_pixels(0, IX * IY, 0, 210);
    drain(); table_en = 0;
    seg_check("ramp", 576, 144, 1, 1);

    // Random pixels with random valid/ready.
    seg_start();
    run_pixels(1, IX * IY, 1, -1);
    drain();
    seg_check("random_bp", 576, 144, 1, 1);

    // Flush mid-frame via i_clear, then a clean ramp frame.
    run_pixels(0, 300, 0, -1);
    step(1, 1, 1, 1, pix_next(0), a);
    seg_start(); table_en = 1;
    run_pixels(0, IX * IY, 0, -1);
    drain(); table_en = 0;
    seg_check("after_clear", 576, 144, 1, 1);

    // Flush mid-frame via reset, then a clean ramp frame.
    run_pixels(0, 300, 0, -1);
    do_reset();
    seg_start(); table_en = 1;
    run_pixels(0, IX * IY, 0, -1);
    drain(); table_en = 0;
    seg_check("after_reset", 576, 144, 1, 1);

    // Two frames back to back with no idle cycle.
    seg_start();
    run_pixels(1, 2 * IX * IY, 0, -1);
    drain();
    seg_check("two_frames", 1152, 288, 2, 2);

    for (int i = 0; i < 12; i++) chk($sformatf("tv%0d_hits", i), 64'(tv_hits[i]), 64'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming KX×KY sliding-window generator for the CNN convolution stages (conv1 on 28×28 input, stage-2 conv on the pooled fmap). It generalises the fixed single-channel window/line-buffer front end with parametrised channel count, stride and bit width. It adds valid/ready backpressure, output-map coordinates and an end-of-frame marker. It sits between the pixel/pool source and the MAC core.

Parameters:
I_BW, 8, bits per channel sample
CI, 1, channels per pixel
IX, 28, input width
IY, 28, input height
KX, 5, window width
KY, 5, window height
STRIDE, 1, window step in x and y (1 or 2)
OUT_W, (IX-KX)/STRIDE+1, derived output width (localparam)
OUT_H, (IY-KY)/STRIDE+1, derived output height (localparam)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous frame flush
i_valid  in  1  input pixel valid
i_ready  out  1  pixel accepted when i_valid && i_ready
i_pixel  in  CI*I_BW  channel c at [c*I_BW +: I_BW]
o_valid  out  1  window valid
o_ready  in  1  downstream ready
o_window  out  KY*KX*CI*I_BW  element (ky,kx,c) at [((ky*KX+kx)*CI+c)*I_BW +: I_BW]; ky=0 top row, kx=0 left column
o_x  out  $clog2(OUT_W)  output-map column
o_y  out  $clog2(OUT_H)  output-map row
o_last  out  1  last window of frame (o_x==OUT_W-1 && o_y==OUT_H-1)

Behaviour:
- Reset (async): col/row counters 0, o_valid 0, o_window 0, o_x 0, o_y 0, o_last 0. Line-buffer and window contents are don't-care.
- i_ready = !o_valid || o_ready. This is a single output register stage with no combinational path from i_valid to o_valid.
- Accepted pixel at (row,col):
  - Writes KY-1 line buffers of depth IX at address col. Buffer k takes buffer k+1's old value; buffer KY-2 takes i_pixel.
  - Shifts the window register array left by one column. The new right column is the KY-1 line-buffer read values plus i_pixel, with i_pixel as the bottom-right element.
- Window emitted on accept iff row>=KY-1, col>=KX-1, (row-(KY-1))%STRIDE==0 and (col-(KX-1))%STRIDE==0.
  - Next cycle: o_valid=1 and o_window = that neighbourhood.
  - o_x = (col-(KX-1))/STRIDE, o_y = (row-(KY-1))/STRIDE; o_last is set per its definition.
  - Latency is 1 clk from the accepting edge.
- Hold rule: while o_valid && !o_ready, all outputs hold stable.
- o_valid clears when o_ready=1 and no new window is produced in the same cycle.
- Counters: col wraps at IX-1, then row increments. Row wraps at IY-1 to start the next frame at (0,0) with no idle cycle required.
- Windows never span a row boundary. Columns 0..KX-2 of each row fill the shift register without emitting.
- i_clear (sync, priority over accept): counters to 0, o_valid 0, o_last 0, and the pixel presented that cycle is dropped.
- Reset or i_clear mid-frame: the next accepted pixel is (0,0). No windows from the old frame are emitted.
- Stride misalignment (e.g. IX=28, KX=5, STRIDE=2): trailing input columns and rows produce no window. o_last marks the last emitted window, not the last input pixel.
- No arithmetic on samples; this is pure data movement.

Decomposition:
- Package cnn_pkg: I_BW, CI, KX, KY default constants, the OUT_W/OUT_H derivation function, and the window index function (ky,kx,c)->bit offset shared with the MAC core.
- One sub-module: line_buffer_ram. It is one row of depth IX and width CI*I_BW, with one write and one async read per cycle, instantiated KY-1 times.

Test Plan:
- Ramp, 28×28, CI=1, STRIDE=1, pixel=(row*28+col) mod 256, o_ready=1 -> first o_valid one clk after the 117th accepted pixel, with element(0,0)=0, element(4,4)=116, o_x=0, o_y=0. The frame contains exactly 576 windows, and o_last is set only on the 576th, with element(4,4)=15 (783 mod 256).
- Same ramp, STRIDE=2 -> 144 windows, o_x/o_y sweep 0..11. The window at o_x=1,o_y=1 has element(0,0)=(2*28+2)=58.
- Backpressure: o_ready=0 for 3 cycles while o_valid=1 -> i_ready=0, o_window/o_x/o_y stable. No window is lost or duplicated, and the total is still 576.
- CI=3, channel c = (pixel+c*64) mod 256 -> each window element's channel slices are offset by 64 and ordered per the packing rule.
- reset_n pulse or i_clear at pixel 300, then a fresh ramp frame -> o_valid=0 within 1 clk. The next frame matches the first scenario exactly.
- Two back-to-back frames with no gap -> 1152 windows, with o_last set on windows 576 and 1152 only.
